// File: rtl/hdmi_video_timing_pkg.sv
// Shared definitions for the HDMI video timing front end: default
// 640x480@60 timing, pattern-mode type, colour-bar table and a clog2 helper.
package hdmi_pkg;

  // Default 640x480@60 timing (pixels / lines)
  localparam int DEF_CLK_DIV  = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    PAT_BARS  = 1'b0,
    PAT_WHITE = 1'b1
  } pat_mode_e;

  // {R,G,B} on/off per bar, left to right:
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [0:7] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  // Bits needed to hold values 0..value-1 (at least 1)
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    if (res < 1) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Video output bundle from the timing generator to the TMDS encoders.
interface hdmi_video_timing_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 8
);
  logic               pixel_clk;
  logic               pix_en;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               frame_start;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (
    output pixel_clk, pix_en, hsync, vsync, de, x, y, frame_start, red, green, blue
  );

  modport slave (
    input pixel_clk, pix_en, hsync, vsync, de, x, y, frame_start, red, green, blue
  );
endinterface

// File: rtl/hdmi_video_timing_pattern_gen.sv
// Combinational test-pattern source: maps column, data-enable and mode to RGB.
// Bar index is found by counting passed bar boundaries, so no divider is needed.
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COLOR_W  = 8,
  parameter int X_W      = 10
) (
  input  logic [X_W-1:0]     x,
  input  logic               de,
  input  pat_mode_e          mode,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_s;
  logic [2:0] sel_s;

  // Bar index = number of bar boundaries at or left of x
  always_comb begin
    bar_s = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_s = bar_s + {2'b00, (x >= X_W'(k * BAR_W))};
    end
  end

  // Select on/off per component and expand to full component width
  always_comb begin
    sel_s = 3'b000;
    if (!de) begin
      sel_s = 3'b000;
    end else if (mode == PAT_WHITE) begin
      sel_s = 3'b111;
    end else begin
      sel_s = BAR_RGB[bar_s];
    end
    red   = {COLOR_W{sel_s[2]}};
    green = {COLOR_W{sel_s[1]}};
    blue  = {COLOR_W{sel_s[0]}};
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// HDMI video front end: divides the TMDS bit clock to the pixel rate, runs
// h/v counters, generates sync/DE and a frame-aligned test pattern.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                btn,
  hdmi_video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = clog2(H_TOTAL);
  localparam int Y_W     = clog2(V_TOTAL);
  localparam int DIV_W   = clog2(CLK_DIV);
  localparam logic HS_ACT = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ACT = (VS_POL != 0) ? 1'b1 : 1'b0;

  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0) || ((H_ACTIVE % 8) != 0)) begin : g_bad_param
    $error("hdmi_video_timing: CLK_DIV must be even and >= 2, H_ACTIVE a multiple of 8");
  end

  logic [DIV_W-1:0]   div_cnt_r;
  logic               pix_en_r;
  logic               pixel_clk_r;
  logic               btn_meta_r;
  logic               btn_sync_r;
  logic [X_W-1:0]     h_cnt_r;
  logic [Y_W-1:0]     v_cnt_r;
  pat_mode_e          mode_r;
  logic               de_r;
  logic               hsync_r;
  logic               vsync_r;
  logic [X_W-1:0]     x_r;
  logic [Y_W-1:0]     y_r;
  logic               frame_start_r;
  logic [COLOR_W-1:0] red_r;
  logic [COLOR_W-1:0] green_r;
  logic [COLOR_W-1:0] blue_r;

  logic               at_origin_s;
  logic               h_last_s;
  logic               v_last_s;
  logic               de_s;
  logic               hs_act_s;
  logic               vs_act_s;
  pat_mode_e          mode_s;
  logic [COLOR_W-1:0] pat_red_s;
  logic [COLOR_W-1:0] pat_green_s;
  logic [COLOR_W-1:0] pat_blue_s;

  // Bit-clock divider counting 0..CLK_DIV-1
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt_r <= DIV_W'(0);
    end else if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
      div_cnt_r <= DIV_W'(0);
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Pixel strobe and 50% duty pixel clock, both registered off the divider
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pix_en_r    <= 1'b0;
      pixel_clk_r <= 1'b0;
    end else begin
      pix_en_r    <= (div_cnt_r == DIV_W'(CLK_DIV - 1));
      pixel_clk_r <= (div_cnt_r < DIV_W'(CLK_DIV / 2));
    end
  end

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      btn_meta_r <= 1'b0;
      btn_sync_r <= 1'b0;
    end else begin
      btn_meta_r <= btn;
      btn_sync_r <= btn_meta_r;
    end
  end

  // Decode counter position into timing flags; mode switches only at (0,0)
  always_comb begin
    at_origin_s = (h_cnt_r == X_W'(0)) && (v_cnt_r == Y_W'(0));
    h_last_s    = (h_cnt_r == X_W'(H_TOTAL - 1));
    v_last_s    = (v_cnt_r == Y_W'(V_TOTAL - 1));
    de_s        = (h_cnt_r < X_W'(H_ACTIVE)) && (v_cnt_r < Y_W'(V_ACTIVE));
    hs_act_s    = (h_cnt_r >= X_W'(H_ACTIVE + H_FP)) &&
                  (h_cnt_r <  X_W'(H_ACTIVE + H_FP + H_SYNC));
    vs_act_s    = (v_cnt_r >= Y_W'(V_ACTIVE + V_FP)) &&
                  (v_cnt_r <  Y_W'(V_ACTIVE + V_FP + V_SYNC));
    if (pix_en_r && at_origin_s) begin
      mode_s = pat_mode_e'(btn_sync_r);
    end else begin
      mode_s = mode_r;
    end
  end

  // Horizontal and vertical position counters, stepped once per pixel
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      h_cnt_r <= X_W'(0);
      v_cnt_r <= Y_W'(0);
    end else if (pix_en_r) begin
      if (h_last_s) begin
        h_cnt_r <= X_W'(0);
        v_cnt_r <= v_last_s ? Y_W'(0) : (v_cnt_r + Y_W'(1));
      end else begin
        h_cnt_r <= h_cnt_r + X_W'(1);
      end
    end
  end

  // Pattern mode latched at the start of each frame
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_r <= PAT_BARS;
    end else begin
      mode_r <= mode_s;
    end
  end

  hdmi_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .COLOR_W  (COLOR_W),
    .X_W      (X_W)
  ) u_pattern (
    .x     (h_cnt_r),
    .de    (de_s),
    .mode  (mode_s),
    .red   (pat_red_s),
    .green (pat_green_s),
    .blue  (pat_blue_s)
  );

  // Video outputs registered from the current position on each pixel strobe
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      de_r    <= 1'b0;
      hsync_r <= ~HS_ACT;
      vsync_r <= ~VS_ACT;
      x_r     <= X_W'(0);
      y_r     <= Y_W'(0);
      red_r   <= COLOR_W'(0);
      green_r <= COLOR_W'(0);
      blue_r  <= COLOR_W'(0);
    end else if (pix_en_r) begin
      de_r    <= de_s;
      hsync_r <= hs_act_s ? HS_ACT : ~HS_ACT;
      vsync_r <= vs_act_s ? VS_ACT : ~VS_ACT;
      x_r     <= h_cnt_r;
      y_r     <= v_cnt_r;
      red_r   <= pat_red_s;
      green_r <= pat_green_s;
      blue_r  <= pat_blue_s;
    end
  end

  // Single-cycle pulse alongside the first appearance of pixel (0,0)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pix_en_r && at_origin_s;
    end
  end

  assign vid.pixel_clk   = pixel_clk_r;
  assign vid.pix_en      = pix_en_r;
  assign vid.hsync       = hsync_r;
  assign vid.vsync       = vsync_r;
  assign vid.de          = de_r;
  assign vid.x           = x_r;
  assign vid.y           = y_r;
  assign vid.frame_start = frame_start_r;
  assign vid.red         = red_r;
  assign vid.green       = green_r;
  assign vid.blue        = blue_r;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: a default 640x480 instance for divider, line
// timing and colour bars, and a tiny instance for frame, button and reset.
module tb_hdmi_video_timing;
  import hdmi_pkg::*;

  localparam int DXW = clog2(800);
  localparam int DYW = clog2(525);
  localparam int SXW = clog2(12);
  localparam int SYW = clog2(7);

  logic clk_in = 1'b0;
  logic rst_d;
  logic rst_s;
  logic btn_d;
  logic btn_s;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  hdmi_video_timing_if #(.X_W(DXW), .Y_W(DYW), .COLOR_W(8)) vid_d ();
  hdmi_video_timing_if #(.X_W(SXW), .Y_W(SYW), .COLOR_W(8)) vid_s ();

  hdmi_video_timing dut_d (
    .clk_in (clk_in),
    .rst_in (rst_d),
    .btn    (btn_d),
    .vid    (vid_d)
  );

  hdmi_video_timing #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clk_in (clk_in),
    .rst_in (rst_s),
    .btn    (btn_s),
    .vid    (vid_s)
  );

  typedef struct {
    int          cyc;
    logic [63:0] val;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb_d[$];
  logic [63:0] sb_s[$];

  int        h_m;
  int        v_m;
  pat_mode_e mode_m;
  int        pix_idx;
  int        de_frame0;
  int        fs_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] pack_d();
    logic [63:0] v;
    v = 64'd0;
    v[49:0] = {vid_d.pixel_clk, vid_d.pix_en, vid_d.frame_start, vid_d.de,
               vid_d.hsync, vid_d.vsync, vid_d.x, vid_d.y,
               vid_d.red, vid_d.green, vid_d.blue};
    return v;
  endfunction

  function automatic logic [63:0] pack_s();
    logic [63:0] v;
    v = 64'd0;
    v[36:0] = {vid_s.pixel_clk, vid_s.pix_en, vid_s.frame_start, vid_s.de,
               vid_s.hsync, vid_s.vsync, vid_s.x, vid_s.y,
               vid_s.red, vid_s.green, vid_s.blue};
    return v;
  endfunction

  // Default instance, sampled mid pixel: pixel_clk=1, pix_en=0, syncs inactive
  function automatic logic [63:0] mk_d(input logic fs, input logic de, input int x,
                                       input int y, input logic [23:0] rgb);
    logic [63:0] v;
    logic [9:0]  xv;
    logic [9:0]  yv;
    xv = 10'(x);
    yv = 10'(y);
    v = 64'd0;
    v[49:0] = {1'b1, 1'b0, fs, de, 1'b1, 1'b1, xv, yv, rgb};
    return v;
  endfunction

  // Reference model of the small instance for one pixel
  function automatic logic [63:0] model_s(input int h, input int v, input pat_mode_e mode);
    logic [63:0] r;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [2:0]  sel;
    logic [3:0]  xv;
    logic [2:0]  yv;
    int          bar;
    de  = (h < 8) && (v < 4);
    hs  = !((h >= 9) && (h < 11));
    vs  = !(v == 5);
    fs  = (h == 0) && (v == 0);
    bar = h / (8 / 8);
    sel = 3'b000;
    if (de && (mode == PAT_WHITE)) begin
      sel = 3'b111;
    end else if (de) begin
      sel[2] = (bar == 0) || (bar == 1) || (bar == 4) || (bar == 5);
      sel[1] = (bar == 0) || (bar == 1) || (bar == 2) || (bar == 3);
      sel[0] = (bar == 0) || (bar == 2) || (bar == 4) || (bar == 6);
    end
    xv = 4'(h);
    yv = 3'(v);
    r = 64'd0;
    r[36:0] = {1'b1, 1'b0, fs, de, hs, vs, xv, yv,
               {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return r;
  endfunction

  // Issue n pixels to the small model and compare each against the DUT
  task automatic small_pixels(input int n);
    logic [63:0] e;
    logic [63:0] o;
    for (int i = 0; i < n; i++) begin
      if ((h_m == 0) && (v_m == 0)) begin
        mode_m = btn_s ? PAT_WHITE : PAT_BARS;
      end
      sb_s.push_back(model_s(h_m, v_m, mode_m));
      h_m = h_m + 1;
      if (h_m == 12) begin
        h_m = 0;
        v_m = (v_m == 6) ? 0 : v_m + 1;
      end
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      e = sb_s.pop_front();
      o = pack_s();
      check("small_pixel", o, e);
      if ((pix_idx < 84) && vid_s.de) de_frame0++;
      if (vid_s.frame_start) fs_seen++;
      pix_idx++;
    end
  endtask

  initial begin
    int        hs_low;
    int        vs_low;
    int        de_cnt;
    int        nfall;
    int        fall_t[2];
    logic      hs_prev;
    sb_entry_t ent;

    rst_d = 1'b1;
    rst_s = 1'b1;
    btn_d = 1'b0;
    btn_s = 1'b0;
    hs_low = 0; vs_low = 0; de_cnt = 0; nfall = 0;
    fall_t[0] = 0; fall_t[1] = 0;
    hs_prev = 1'b1;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_default", pack_d(), {14'd0, 6'b000011, 44'd0});
    check("reset_small", pack_s(), {27'd0, 6'b000011, 31'd0});

    // Default instance: expected pixels at cycle after edge 10*(p+1)+1
    sb_d.push_back('{11,   mk_d(1'b1, 1'b1, 0,   0, 24'hFFFFFF), "bar_x0"});
    sb_d.push_back('{811,  mk_d(1'b0, 1'b1, 80,  0, 24'hFFFF00), "bar_x80"});
    sb_d.push_back('{1611, mk_d(1'b0, 1'b1, 160, 0, 24'h00FFFF), "bar_x160"});
    sb_d.push_back('{6401, mk_d(1'b0, 1'b1, 639, 0, 24'h000000), "bar_x639"});
    sb_d.push_back('{6411, mk_d(1'b0, 1'b0, 640, 0, 24'h000000), "blank_x640"});
    sb_d.push_back('{8011, mk_d(1'b0, 1'b1, 0,   1, 24'hFFFFFF), "line1_x0"});

    @(negedge clk_in);
    rst_d = 1'b0;
    for (int k = 1; k <= 16500; k++) begin
      @(posedge clk_in);
      #1;
      if (k <= 30) begin
        check("pix_en", {63'd0, vid_d.pix_en}, {63'd0, ((k % 10) == 0)});
        check("pixel_clk", {63'd0, vid_d.pixel_clk}, {63'd0, (((k - 1) % 10) < 5)});
      end
      if (k <= 8000) begin
        if (!vid_d.hsync) hs_low++;
        if (vid_d.de) de_cnt++;
      end
      if (hs_prev && !vid_d.hsync && (nfall < 2)) begin
        fall_t[nfall] = k;
        nfall++;
      end
      hs_prev = vid_d.hsync;
      if (!vid_d.vsync) vs_low++;
      if ((sb_d.size() > 0) && (sb_d[0].cyc == k)) begin
        ent = sb_d.pop_front();
        check(ent.tag, pack_d(), ent.val);
      end
    end
    check("hsync_first_fall", 64'(fall_t[0]), 64'd6571);
    check("hsync_period", 64'(fall_t[1] - fall_t[0]), 64'd8000);
    check("hsync_low_cycles", 64'(hs_low), 64'd960);
    check("de_cycles_line0", 64'(de_cnt), 64'd6400);
    check("vsync_inactive", 64'(vs_low), 64'd0);
    check("default_sb_drained", 64'(sb_d.size()), 64'd0);

    // Small instance: bars, white after press, bars after release,
    // then a short press inside one frame that must be ignored
    h_m = 0; v_m = 0; mode_m = PAT_BARS; pix_idx = 0; de_frame0 = 0; fs_seen = 0;
    @(negedge clk_in);
    rst_s = 1'b0;
    @(posedge clk_in);
    small_pixels(30);
    btn_s = 1'b1;
    small_pixels(70);
    btn_s = 1'b0;
    small_pixels(80);
    btn_s = 1'b1;
    small_pixels(20);
    btn_s = 1'b0;
    small_pixels(141);
    check("small_de_frame0", 64'(de_frame0), 64'd32);
    check("small_frame_starts", 64'(fs_seen), 64'd5);

    // Asynchronous reset mid-line: immediate clear, restart at (0,0) with bars
    @(posedge clk_in);
    #2;
    rst_s = 1'b1;
    #1;
    check("small_async_reset", pack_s(), {27'd0, 6'b000011, 31'd0});
    @(negedge clk_in);
    rst_s = 1'b0;
    h_m = 0; v_m = 0; mode_m = PAT_BARS;
    sb_s.delete();
    @(posedge clk_in);
    small_pixels(85);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
